// File: rtl/seg_serial_rx.sv
// Receiver for the 4-wire serial display bus {CLK, DO, PEN, CLR}: oversamples the bus on clk,
// shifts DO in on CLK rising edges and emits one parallel frame per PEN rising edge.
module seg_serial_rx #(
  parameter int unsigned FRAME_BITS  = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_in,
  input  logic                  sdo_in,
  input  logic                  pen_in,
  input  logic                  clr_in,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [6:0]            bit_count,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);

  localparam logic [6:0] FrameBitsW = 7'(FRAME_BITS);

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  // Bus lines packed as {sclk, sdo, pen, clr} so all four share one equal-delay path.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  prev_q, synced;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [7:0]            fcnt_q, fcnt_d;
  logic                  shift_ev, latch_ev, clr_lvl;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign shift_ev = synced[3] & ~prev_q[3];
  assign latch_ev = synced[1] & ~prev_q[1];
  assign clr_lvl  = ~synced[0];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], {sclk_in, sdo_in, pen_in, clr_in}};
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;

    if (clr_lvl) begin
      shift_d = '0;
      cnt_d   = '0;
      state_d = StIdle;
    end else begin
      // Shift is applied before latch so a coincident bit lands in the latched frame.
      if (shift_ev) begin
        shift_d = {shift_q[FRAME_BITS-2:0], synced[2]};
        cnt_d   = (cnt_q == 7'd127) ? 7'd127 : cnt_q + 7'd1;
      end
      unique case (state_q)
        StIdle:  if (shift_ev && !latch_ev) state_d = StShift;
        StShift: ;
        StLatch: state_d = shift_ev ? StShift : StIdle;
        default: state_d = StIdle;
      endcase
      if (latch_ev && state_q != StLatch) begin
        data_d  = shift_d;
        valid_d = 1'b1;
        err_d   = (cnt_d != FrameBitsW);
        fcnt_d  = fcnt_q + 8'd1;
        cnt_d   = '0;
        state_d = StLatch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= '0;
      state_q <= StIdle;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= synced;
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign bit_count   = cnt_q;
  assign frame_cnt   = fcnt_q;
  assign busy        = (state_q == StShift);

endmodule

// File: tb/tb_seg_serial_rx.sv
// Directed bench for seg_serial_rx: table of frames plus hand-written clear, coincident-edge,
// counter-wrap and mid-frame reset sequences.
module tb_seg_serial_rx;

  logic        clk = 1'b0;
  logic        rst, sclk_in, sdo_in, pen_in, clr_in;
  logic [63:0] frame_data;
  logic        frame_valid, frame_err, busy;
  logic [6:0]  bit_count;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  seg_serial_rx #(.FRAME_BITS(64), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk_in     (sclk_in),
    .sdo_in      (sdo_in),
    .pen_in      (pen_in),
    .clr_in      (clr_in),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .bit_count   (bit_count),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  typedef struct {
    logic [127:0] data;
    int           nbits;
    logic [63:0]  mask;
    logic         exp_err;
  } vec_t;

  int          n_cmp = 0, n_fail = 0, vcount = 0;
  logic [63:0] cap_data;
  logic        cap_err;
  logic [63:0] m_shift;
  logic [7:0]  m_fcnt;

  always @(negedge clk) begin
    if (frame_valid) begin
      vcount   = vcount + 1;
      cap_data = frame_data;
      cap_err  = frame_err;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int hp);
    sdo_in  = b;
    sclk_in = 1'b0;
    tick(hp);
    sclk_in = 1'b1;
    m_shift = {m_shift[62:0], b};
    tick(hp);
  endtask

  task automatic send_bits(input logic [127:0] d, input int n, input int hp);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i], hp);
  endtask

  task automatic pen_pulse(input int hp);
    pen_in = 1'b1;
    tick(hp);
    pen_in = 1'b0;
    tick(hp);
    m_fcnt = m_fcnt + 8'd1;
  endtask

  vec_t vecs[4];

  initial begin
    int          v0;
    logic [63:0] held, d4;

    vecs[0] = '{data: 128'hDEADBEEF_01234567, nbits: 64, mask: '1, exp_err: 1'b0};
    vecs[1] = '{data: 128'h0123_4567_89AB_CDEF, nbits: 60, mask: 64'h0FFF_FFFF_FFFF_FFFF,
                exp_err: 1'b1};
    vecs[2] = '{data: 128'hA5A5_5A5A_0F0F_F0F0, nbits: 64, mask: '1, exp_err: 1'b0};
    vecs[3] = '{data: 128'h3F_0011_2233_4455_6677, nbits: 70, mask: '1, exp_err: 1'b1};

    rst = 1'b1; sclk_in = 1'b0; sdo_in = 1'b0; pen_in = 1'b0; clr_in = 1'b1;
    m_shift = '0; m_fcnt = '0;
    tick(3);
    chk("reset frame_data", frame_data, 0);
    chk("reset flags", {frame_valid, frame_err, busy}, 0);
    chk("reset bit_count", bit_count, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 4; i++) begin
      v0 = vcount;
      send_bits(vecs[i].data, vecs[i].nbits, 4);
      chk($sformatf("v%0d busy", i), busy, 1);
      chk($sformatf("v%0d bit_count", i), bit_count, vecs[i].nbits);
      pen_pulse(4);
      chk($sformatf("v%0d valid pulses", i), vcount, v0 + 1);
      chk($sformatf("v%0d data table", i), cap_data & vecs[i].mask,
          vecs[i].data[63:0] & vecs[i].mask);
      chk($sformatf("v%0d data model", i), cap_data, m_shift);
      chk($sformatf("v%0d err", i), cap_err, vecs[i].exp_err);
      chk($sformatf("v%0d frame_cnt", i), frame_cnt, m_fcnt);
      chk($sformatf("v%0d idle after latch", i), {busy, bit_count}, 0);
    end

    // Clear mid-frame, then a full frame of ones.
    send_bits(128'h1234_5678, 32, 4);
    held   = frame_data;
    clr_in = 1'b0;
    tick(4);
    chk("clr frame_data held", frame_data, held);
    chk("clr bit_count", bit_count, 0);
    chk("clr busy", busy, 0);
    clr_in  = 1'b1;
    m_shift = '0;
    tick(4);
    v0 = vcount;
    send_bits({64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 64, 4);
    pen_pulse(4);
    chk("clr-ones valid", vcount, v0 + 1);
    chk("clr-ones data", cap_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("clr-ones err", cap_err, 0);

    // Final sclk edge and pen edge on the same clk edge.
    d4 = 64'hC3C3_1234_5678_9AB1;
    v0 = vcount;
    send_bits({64'h0, d4 >> 1}, 63, 4);
    chk("coinc bit_count 63", bit_count, 63);
    sdo_in  = d4[0];
    sclk_in = 1'b0;
    tick(4);
    sclk_in = 1'b1;
    pen_in  = 1'b1;
    m_shift = {m_shift[62:0], d4[0]};
    tick(4);
    pen_in  = 1'b0;
    m_fcnt  = m_fcnt + 8'd1;
    tick(4);
    chk("coinc valid", vcount, v0 + 1);
    chk("coinc data", cap_data, d4);
    chk("coinc err", cap_err, 0);
    chk("coinc frame_cnt", frame_cnt, m_fcnt);

    // Reset after 20 shifts discards the partial frame.
    send_bits(128'hABCDE, 20, 4);
    chk("pre-rst bit_count", bit_count, 20);
    v0 = vcount;
    rst = 1'b1; sclk_in = 1'b0;
    tick(1);
    chk("rst frame_data", frame_data, 0);
    chk("rst bit_count", bit_count, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst flags", {frame_valid, frame_err, busy}, 0);
    rst = 1'b0; m_shift = '0; m_fcnt = '0;
    tick(10);
    chk("rst no valid", vcount, v0);

    // 256 short frames wrap the frame counter.
    v0 = vcount;
    for (int f = 0; f < 256; f++) begin
      send_bits(128'h9, 4, 3);
      pen_pulse(3);
      if (f == 254) chk("wrap frame_cnt 255", frame_cnt, 255);
    end
    chk("wrap frame_cnt 0", frame_cnt, 0);
    chk("wrap valid pulses", vcount, v0 + 256);
    chk("short frame err", cap_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
